// File: rtl/seq_mult_controller.sv
// Sequential shift-and-add multiplier controller.
// One M_WIDTH-bit add row is reused for each of the Q_WIDTH multiplier bits.
module seq_mult_controller #(
    parameter int M_WIDTH = 3,
    parameter int Q_WIDTH = 2
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [M_WIDTH-1:0]             m,
    input  logic [Q_WIDTH-1:0]             q,
    input  logic                           result_ack,
    output logic                           busy,
    output logic                           result_valid,
    output logic [M_WIDTH+Q_WIDTH-1:0]     product,
    output logic [$clog2(Q_WIDTH+1)-1:0]   bit_index
);

    localparam int P_W   = M_WIDTH + Q_WIDTH;
    localparam int IDX_W = $clog2(Q_WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(Q_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [M_WIDTH-1:0] m_q, m_d;
    logic [Q_WIDTH-1:0] q_q, q_d;
    logic [P_W-1:0]     acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               q_bit;
    logic [P_W-1:0]     addend;

    // Current multiplier bit and the shifted multiplicand row
    always_comb begin
        q_bit  = |(q_q & (Q_WIDTH'(1) << idx_q));
        addend = P_W'(m_q) << idx_q;
    end

    // Next-state logic: accept, accumulate one row per cycle, hold until ack
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = m;
                    q_d     = q;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (q_bit) begin
                    acc_d = acc_q + addend;
                end
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (result_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    // Status decode and product exposure
    always_comb begin
        busy         = (state_q != IDLE);
        result_valid = (state_q == DONE);
        product      = acc_q;
        bit_index    = idx_q;
    end

endmodule

// File: tb/tb_seq_mult_controller.sv
// Testbench for seq_mult_controller.
// Directed vectors with a cycle-level behavioural model and literal checks.
module tb_seq_mult_controller;

    localparam int MW = 3;
    localparam int QW = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] m = '0;
    logic [1:0] q = '0;
    logic       result_ack = 1'b0;
    logic       busy;
    logic       result_valid;
    logic [4:0] product;
    logic [1:0] bit_index;

    logic       start4 = 1'b0;
    logic [3:0] m4 = '0;
    logic [3:0] q4 = '0;
    logic       ack4 = 1'b0;
    logic       busy4;
    logic       valid4;
    logic [7:0] prod4;
    logic [2:0] idx4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    seq_mult_controller #(.M_WIDTH(MW), .Q_WIDTH(QW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .m(m), .q(q),
        .result_ack(result_ack), .busy(busy), .result_valid(result_valid),
        .product(product), .bit_index(bit_index)
    );

    seq_mult_controller #(.M_WIDTH(4), .Q_WIDTH(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .start(start4), .m(m4), .q(q4),
        .result_ack(ack4), .busy(busy4), .result_valid(valid4),
        .product(prod4), .bit_index(idx4)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 running, 2 holding a result
    int mst = 0;
    int cnt = 0;
    int mm_c = 0;
    int mq_c = 0;
    int last = 0;

    always @(negedge reset_n) begin
        mst = 0;
        cnt = 0;
        last = 0;
    end

    always @(posedge clock) begin
        int eprod;
        int ebit;
        if (reset_n) begin
            case (mst)
                0: if (start) begin
                    mm_c = int'(m);
                    mq_c = int'(q);
                    cnt = QW;
                    mst = 1;
                end
                1: begin
                    cnt--;
                    if (cnt == 0) begin
                        mst = 2;
                        last = mm_c * mq_c;
                    end
                end
                default: if (result_ack) mst = 0;
            endcase
        end
        #1;
        if (mst == 1) begin
            eprod = mm_c * (mq_c % (1 << (QW - cnt)));
            ebit = QW - cnt;
        end else begin
            eprod = last;
            ebit = 0;
        end
        chk("mdl_busy", busy, (mst != 0));
        chk("mdl_valid", result_valid, (mst == 2));
        chk("mdl_product", product, eprod);
        chk("mdl_bit_index", bit_index, ebit);
    end

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!result_valid && n < 20);
        if (!result_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_valid timeout got 0 want 1");
        end
    endtask

    task automatic run_mult(input int mm, input int qq, input string nm);
        int n;
        @(negedge clock);
        start = 1'b1;
        m = 3'(mm);
        q = 2'(qq);
        @(posedge clock);
        #1;
        chk({nm, "_busy"}, busy, 1);
        @(negedge clock);
        start = 1'b0;
        wait_valid(n);
        chk({nm, "_latency"}, n + 1, QW + 1);
        chk({nm, "_product"}, product, mm * qq);
    endtask

    task automatic ack_it(input string nm);
        @(negedge clock);
        result_ack = 1'b1;
        @(posedge clock);
        #1;
        chk({nm, "_ack_busy"}, busy, 0);
        chk({nm, "_ack_valid"}, result_valid, 0);
        @(negedge clock);
        result_ack = 1'b0;
    endtask

    task automatic run4(input int mm, input int qq, input int expv);
        int n;
        @(negedge clock);
        start4 = 1'b1;
        m4 = 4'(mm);
        q4 = 4'(qq);
        @(posedge clock);
        #1;
        chk("d4_busy", busy4, 1);
        @(negedge clock);
        start4 = 1'b0;
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!valid4 && n < 20);
        chk("d4_latency", n + 1, 5);
        chk("d4_product", prod4, expv);
        @(negedge clock);
        ack4 = 1'b1;
        @(posedge clock);
        #1;
        chk("d4_ack_busy", busy4, 0);
        @(negedge clock);
        ack4 = 1'b0;
    endtask

    initial begin
        int n;
        int prev;
        int acc_cyc;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_product", product, 0);
        chk("rst_bit_index", bit_index, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Basic multiply with held result
        run_mult(7, 3, "basic");
        chk("basic_lit", product, 21);
        repeat (5) begin
            @(posedge clock);
            #1;
            chk("hold_valid", result_valid, 1);
            chk("hold_product", product, 21);
        end
        ack_it("basic");
        chk("after_ack_product", product, 21);

        // Zero operands keep the full latency
        run_mult(5, 0, "zero_q");
        chk("zero_q_lit", product, 0);
        ack_it("zero_q");
        run_mult(0, 2, "zero_m");
        ack_it("zero_m");

        // start and operand changes during RUN are ignored
        @(negedge clock);
        start = 1'b1;
        m = 3'd6;
        q = 2'd2;
        @(posedge clock);
        @(negedge clock);
        m = 3'd7;
        q = 2'd3;
        @(negedge clock);
        start = 1'b0;
        m = 3'd1;
        q = 2'd1;
        wait_valid(n);
        chk("robust_product", product, 12);

        // ack and start together in DONE: return first, accept next edge
        @(negedge clock);
        result_ack = 1'b1;
        start = 1'b1;
        m = 3'd3;
        q = 2'd1;
        @(posedge clock);
        #1;
        chk("both_busy", busy, 0);
        chk("both_valid", result_valid, 0);
        @(negedge clock);
        result_ack = 1'b0;
        @(posedge clock);
        #1;
        chk("both_accept", busy, 1);
        @(negedge clock);
        start = 1'b0;
        wait_valid(n);
        chk("both_product", product, 3);
        ack_it("both");

        // Asynchronous reset in the middle of RUN
        @(negedge clock);
        start = 1'b1;
        m = 3'd5;
        q = 2'd3;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", result_valid, 0);
        chk("arst_product", product, 0);
        chk("arst_bit_index", bit_index, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) begin
            @(posedge clock);
            #1;
            chk("arst_no_valid", result_valid, 0);
        end
        run_mult(4, 3, "post_rst");
        chk("post_rst_lit", product, 12);
        ack_it("post_rst");

        // Exhaustive sweep back to back
        prev = -1;
        for (int mi = 0; mi < 8; mi++) begin
            for (int qi = 0; qi < 4; qi++) begin
                @(negedge clock);
                result_ack = 1'b0;
                start = 1'b1;
                m = 3'(mi);
                q = 2'(qi);
                @(posedge clock);
                #1;
                acc_cyc = cyc;
                if (prev >= 0) chk("sweep_period", acc_cyc - prev, 4);
                prev = acc_cyc;
                @(negedge clock);
                start = 1'b0;
                wait_valid(n);
                chk("sweep_latency", n + 1, 3);
                chk("sweep_product", product, mi * qi);
                @(negedge clock);
                result_ack = 1'b1;
                @(posedge clock);
            end
        end
        @(negedge clock);
        result_ack = 1'b0;

        // Wider build
        run4(15, 15, 225);
        run4(9, 6, 54);

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
